// File: rtl/vm2002_change.sv
// Change dispenser: pays a cent balance from a three-denomination hopper,
// largest coin first, with per-coin ack timeout and supplier refills.
//
// state  | meaning
// IDLE   | waiting for a balance; refills accepted here only
// SELECT | choose next coin or finish (paid out / short)
// ISSUE  | coin_req held until coin_ack or ack timer expiry (jam)
// DONE   | one-cycle done pulse, then back to IDLE
module vm2002_change (
  input  logic        clk,
  input  logic        hrst_n,
  input  logic        srst,
  input  logic [15:0] balance,
  input  logic        bal_valid,
  input  logic        coin_ack,
  input  logic        refill_valid,
  input  logic [1:0]  refill_type,
  input  logic [3:0]  refill_count,
  output logic        coin_req,
  output logic [1:0]  coin_out,
  output logic        busy,
  output logic        done,
  output logic        short,
  output logic        jam,
  output logic [15:0] shortfall,
  output logic [7:0]  nickel_cnt,
  output logic [7:0]  dime_cnt,
  output logic [7:0]  quarter_cnt
);

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;

  localparam logic [1:0] COIN_N = 2'b01;
  localparam logic [1:0] COIN_D = 2'b10;
  localparam logic [1:0] COIN_Q = 2'b11;

  state_t      state;
  logic [15:0] remaining;
  logic [7:0]  ack_timer;
  logic [1:0]  pick_type;
  logic [15:0] coin_val;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Largest coin that fits the remaining balance and is actually stocked.
  always_comb begin
    pick_type = 2'b00;
    if (remaining >= 16'd25 && quarter_cnt != 8'd0)
      pick_type = COIN_Q;
    else if (remaining >= 16'd10 && dime_cnt != 8'd0)
      pick_type = COIN_D;
    else if (remaining >= 16'd5 && nickel_cnt != 8'd0)
      pick_type = COIN_N;
  end

  always_comb begin
    case (coin_out)
      COIN_Q:  coin_val = 16'd25;
      COIN_D:  coin_val = 16'd10;
      COIN_N:  coin_val = 16'd5;
      default: coin_val = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) begin
      state       <= IDLE;
      remaining   <= 16'd0;
      ack_timer   <= 8'd0;
      coin_req    <= 1'b0;
      coin_out    <= 2'b00;
      busy        <= 1'b0;
      done        <= 1'b0;
      short       <= 1'b0;
      jam         <= 1'b0;
      shortfall   <= 16'd0;
      nickel_cnt  <= 8'd0;
      dime_cnt    <= 8'd0;
      quarter_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (refill_valid) begin
            case (refill_type)
              COIN_N:  nickel_cnt  <= sat_add(nickel_cnt, refill_count);
              COIN_D:  dime_cnt    <= sat_add(dime_cnt, refill_count);
              COIN_Q:  quarter_cnt <= sat_add(quarter_cnt, refill_count);
              default: ;
            endcase
          end
          if (bal_valid) begin
            remaining <= balance;
            short     <= 1'b0;
            jam       <= 1'b0;
            shortfall <= 16'd0;
            busy      <= 1'b1;
            state     <= SELECT;
          end
        end

        SELECT: begin
          if (srst) begin
            coin_req <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            state    <= IDLE;
          end else if (remaining == 16'd0) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (pick_type != 2'b00) begin
            coin_out  <= pick_type;
            coin_req  <= 1'b1;
            ack_timer <= 8'hFF;
            state     <= ISSUE;
          end else begin
            short     <= 1'b1;
            shortfall <= remaining;
            done      <= 1'b1;
            state     <= DONE;
          end
        end

        ISSUE: begin
          if (srst) begin
            coin_req <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            state    <= IDLE;
          end else if (coin_ack) begin
            remaining <= (remaining >= coin_val) ? remaining - coin_val : 16'd0;
            case (coin_out)
              COIN_N:  if (nickel_cnt  != 8'd0) nickel_cnt  <= nickel_cnt  - 8'd1;
              COIN_D:  if (dime_cnt    != 8'd0) dime_cnt    <= dime_cnt    - 8'd1;
              COIN_Q:  if (quarter_cnt != 8'd0) quarter_cnt <= quarter_cnt - 8'd1;
              default: ;
            endcase
            coin_req <= 1'b0;
            state    <= SELECT;
          end else if (ack_timer == 8'd0) begin
            // Hopper never answered: the coin is not counted as paid.
            jam       <= 1'b1;
            short     <= 1'b1;
            shortfall <= remaining;
            coin_req  <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            ack_timer <= ack_timer - 8'd1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vm2002_change.sv
// Directed bench for vm2002_change: table of payout scenarios plus
// hand-written jam, abort, refill and reset sequences.
module tb_vm2002_change;

  logic        clk = 1'b0;
  logic        hrst_n, srst, bal_valid, coin_ack, refill_valid;
  logic [15:0] balance;
  logic [1:0]  refill_type;
  logic [3:0]  refill_count;
  logic        coin_req, busy, done, short, jam;
  logic [1:0]  coin_out;
  logic [15:0] shortfall;
  logic [7:0]  nickel_cnt, dime_cnt, quarter_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vm2002_change dut (
    .clk(clk), .hrst_n(hrst_n), .srst(srst), .balance(balance), .bal_valid(bal_valid),
    .coin_ack(coin_ack), .refill_valid(refill_valid), .refill_type(refill_type),
    .refill_count(refill_count), .coin_req(coin_req), .coin_out(coin_out), .busy(busy),
    .done(done), .short(short), .jam(jam), .shortfall(shortfall),
    .nickel_cnt(nickel_cnt), .dime_cnt(dime_cnt), .quarter_cnt(quarter_cnt)
  );

  typedef struct {
    logic [7:0]  q, d, n;
    logic [15:0] bal;
    int          ncoins;
    logic [15:0] coins;
    logic        sh;
    logic [15:0] sf;
    logic [7:0]  eq, ed, en;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic hard_reset();
    hrst_n = 1'b0; srst = 1'b0; bal_valid = 1'b0; coin_ack = 1'b0;
    refill_valid = 1'b0; refill_type = 2'b00; refill_count = 4'd0; balance = 16'd0;
    repeat (2) @(negedge clk);
    hrst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic refill(input logic [1:0] t, input logic [3:0] c);
    refill_valid = 1'b1; refill_type = t; refill_count = c;
    @(negedge clk);
    refill_valid = 1'b0; refill_type = 2'b00; refill_count = 4'd0;
  endtask

  task automatic fill(input logic [1:0] t, input int amount);
    int left;
    int c;
    left = amount;
    while (left > 0) begin
      c = (left > 15) ? 15 : left;
      refill(t, c[3:0]);
      left -= c;
    end
  endtask

  // Acks every request one cycle after it is seen; records coins and the result.
  task automatic run_payout(input logic [15:0] bal, input int budget, output int n,
                            output logic [15:0] coins, output logic got_done,
                            output logic sh, output logic jm, output logic [15:0] sf);
    n = 0; coins = 16'd0; got_done = 1'b0; sh = 1'b0; jm = 1'b0; sf = 16'd0;
    balance = bal; bal_valid = 1'b1;
    @(negedge clk);
    bal_valid = 1'b0;
    for (int cyc = 0; cyc < budget && !got_done; cyc++) begin
      coin_ack = coin_req;
      if (coin_req) begin
        if (n < 8) coins[2*n +: 2] = coin_out;
        n++;
      end
      if (done) begin
        got_done = 1'b1; sh = short; jm = jam; sf = shortfall;
      end
      @(negedge clk);
    end
    coin_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n, cnt, w;
    logic [15:0] coins, sf;
    logic gd, sh, jm, bad, saw;

    //         q     d     n     bal   #  coins    sh  sf      eq    ed    en
    vecs[0] = '{8'd4,   8'd4,   8'd4,   16'd65, 4, 16'h006F, 1'b0, 16'd0,  8'd2,   8'd3,   8'd3};
    vecs[1] = '{8'd0,   8'd1,   8'd10,  16'd30, 5, 16'h0156, 1'b0, 16'd0,  8'd0,   8'd0,   8'd6};
    vecs[2] = '{8'd255, 8'd255, 8'd255, 16'd7,  1, 16'h0001, 1'b1, 16'd2,  8'd255, 8'd255, 8'd254};
    vecs[3] = '{8'd1,   8'd0,   8'd0,   16'd0,  0, 16'h0000, 1'b0, 16'd0,  8'd1,   8'd0,   8'd0};
    vecs[4] = '{8'd0,   8'd0,   8'd0,   16'd40, 0, 16'h0000, 1'b1, 16'd40, 8'd0,   8'd0,   8'd0};
    vecs[5] = '{8'd1,   8'd0,   8'd3,   16'd45, 4, 16'h0057, 1'b1, 16'd5,  8'd0,   8'd0,   8'd0};
    vecs[6] = '{8'd2,   8'd2,   8'd0,   16'd3,  0, 16'h0000, 1'b1, 16'd3,  8'd2,   8'd2,   8'd0};

    hard_reset();
    check("rst_coin_req", coin_req, 0);
    check("rst_coin_out", coin_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_short", short, 0);
    check("rst_jam", jam, 0);
    check("rst_shortfall", shortfall, 0);
    check("rst_counts", {nickel_cnt, dime_cnt, quarter_cnt}, 0);

    for (int i = 0; i < 7; i++) begin
      hard_reset();
      fill(2'b11, vecs[i].q);
      fill(2'b10, vecs[i].d);
      fill(2'b01, vecs[i].n);
      run_payout(vecs[i].bal, 200, n, coins, gd, sh, jm, sf);
      check($sformatf("v%0d_done", i), gd, 1);
      check($sformatf("v%0d_ncoins", i), n, vecs[i].ncoins);
      check($sformatf("v%0d_coins", i), coins, vecs[i].coins);
      check($sformatf("v%0d_short", i), sh, vecs[i].sh);
      check($sformatf("v%0d_jam", i), jm, 0);
      check($sformatf("v%0d_shortfall", i), sf, vecs[i].sf);
      check($sformatf("v%0d_q", i), quarter_cnt, vecs[i].eq);
      check($sformatf("v%0d_d", i), dime_cnt, vecs[i].ed);
      check($sformatf("v%0d_n", i), nickel_cnt, vecs[i].en);
      check($sformatf("v%0d_busy_after", i), busy, 0);
    end

    // Jam: no ack at all, timeout 256 cycles after coin_req rises.
    hard_reset();
    fill(2'b11, 1);
    balance = 16'd25; bal_valid = 1'b1;
    @(negedge clk);
    bal_valid = 1'b0;
    check("jam_req_not_yet", coin_req, 0);
    check("jam_busy", busy, 1);
    @(negedge clk);
    check("jam_req_latency", coin_req, 1);
    check("jam_coin_out", coin_out, 2'b11);
    cnt = 0; bad = 1'b0;
    while (!done && cnt < 400) begin
      @(negedge clk);
      cnt++;
      if (!done && (!coin_req || coin_out != 2'b11)) bad = 1'b1;
    end
    check("jam_req_stable", bad, 0);
    check("jam_latency", cnt, 256);
    check("jam_flag", jam, 1);
    check("jam_short", short, 1);
    check("jam_shortfall", shortfall, 25);
    check("jam_q_kept", quarter_cnt, 1);
    check("jam_req_dropped", coin_req, 0);
    @(negedge clk);
    check("jam_done_pulse", done, 0);
    check("jam_idle", busy, 0);

    // Abort during the second ISSUE of a 65-cent payout.
    hard_reset();
    fill(2'b11, 4); fill(2'b10, 4); fill(2'b01, 4);
    balance = 16'd65; bal_valid = 1'b1;
    @(negedge clk);
    bal_valid = 1'b0;
    w = 0;
    while (!coin_req && w < 20) begin @(negedge clk); w++; end
    check("abort_req1", coin_req, 1);
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    w = 0;
    while (!coin_req && w < 20) begin @(negedge clk); w++; end
    check("abort_req2", coin_req, 1);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    check("abort_req_low", coin_req, 0);
    check("abort_busy_low", busy, 0);
    saw = done;
    repeat (10) begin @(negedge clk); if (done) saw = 1'b1; end
    check("abort_no_done", saw, 0);
    check("abort_q", quarter_cnt, 3);
    check("abort_d", dime_cnt, 4);
    check("abort_n", nickel_cnt, 4);
    srst = 1'b1;
    repeat (2) @(negedge clk);
    srst = 1'b0;
    check("idle_srst_counts", {nickel_cnt, dime_cnt, quarter_cnt}, {8'd4, 8'd4, 8'd3});
    check("idle_srst_busy", busy, 0);

    // Refill saturation, refill ignored while busy, async reset mid-payout.
    hard_reset();
    fill(2'b11, 250);
    check("refill_250", quarter_cnt, 250);
    refill(2'b11, 4'd15);
    check("refill_sat", quarter_cnt, 255);
    balance = 16'd25; bal_valid = 1'b1;
    @(negedge clk);
    bal_valid = 1'b0;
    @(negedge clk);
    check("busy_refill_issue", coin_req, 1);
    refill(2'b11, 4'd15);
    refill(2'b01, 4'd5);
    check("busy_refill_q", quarter_cnt, 255);
    check("busy_refill_n", nickel_cnt, 0);
    #2 hrst_n = 1'b0;
    #1;
    check("async_rst_req", coin_req, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_q", quarter_cnt, 0);
    @(negedge clk);
    hrst_n = 1'b1;
    @(negedge clk);

    // Refill and balance in the same IDLE cycle: SELECT sees the new coin.
    balance = 16'd25; bal_valid = 1'b1;
    refill_valid = 1'b1; refill_type = 2'b11; refill_count = 4'd1;
    @(negedge clk);
    bal_valid = 1'b0; refill_valid = 1'b0; refill_type = 2'b00; refill_count = 4'd0;
    @(negedge clk);
    check("coincide_req", coin_req, 1);
    check("coincide_coin", coin_out, 2'b11);
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    w = 0;
    while (!done && w < 20) begin @(negedge clk); w++; end
    check("coincide_done", done, 1);
    check("coincide_short", short, 0);
    check("coincide_q", quarter_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vm2002_change.md
VM2002_CHANGE -- requirements
Module: vm2002_change

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: hrst_n  input  1  async active-low reset.
REQ-004 SHALL have port: srst  input  1  sync abort, active-high.
REQ-005 SHALL have port: balance  input  16  change owed, cents.
REQ-006 SHALL have port: bal_valid  input  1  balance-valid strobe, sampled only in IDLE.
REQ-007 SHALL have port: coin_ack  input  1  hopper ack, one coin ejected.
REQ-008 SHALL have port: refill_valid  input  1  supplier refill strobe.
REQ-009 SHALL have port: refill_type  input  2  01 nickel, 10 dime, 11 quarter, 00 ignored.
REQ-010 SHALL have port: refill_count  input  4  coins added.
REQ-011 SHALL have port: coin_req  output  1  eject request to hopper.
REQ-012 SHALL have port: coin_out  output  2  denomination requested, same encoding as refill_type.
REQ-013 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port: short  output  1  exact change not paid, valid with done.
REQ-016 SHALL have port: jam  output  1  ack timeout, valid with done.
REQ-017 SHALL have port: shortfall  output  16  cents unpaid, held until next accept.
REQ-018 SHALL have ports: nickel_cnt, dime_cnt, quarter_cnt  output  8 each  hopper inventory.

Function
REQ-019 SHALL implement states IDLE, SELECT, ISSUE, DONE.
REQ-020 SHALL in IDLE, on bal_valid=1, load remaining<=balance and clear short, jam and shortfall; SHALL go to SELECT next cycle.
REQ-021 SHALL in SELECT, when remaining=0, go to DONE.
REQ-022 SHALL in SELECT otherwise pick the largest denomination d (25, 10, 5) with d<=remaining and inventory>0, latch it, and go to ISSUE.
REQ-023 SHALL in SELECT with no usable coin (includes remaining 1..4) set short=1, shortfall=remaining, and go to DONE.
REQ-024 SHALL in ISSUE drive coin_req=1 with coin_out stable until coin_ack is sampled high; first coin_req SHALL occur 2 cycles after the bal_valid edge.
REQ-025 SHALL on the ack cycle subtract d from remaining, decrement that inventory by 1, drop coin_req next cycle, and return to SELECT.
REQ-026 SHALL ignore coin_ack outside ISSUE.
REQ-027 SHALL reset an 8-bit ack timer on ISSUE entry; if 256 cycles pass without ack, SHALL set jam=1, short=1, shortfall=remaining (coin not deducted), and go to DONE.
REQ-028 SHALL in DONE pulse done=1 for one cycle and return to IDLE.
REQ-029 SHALL accept refill only in IDLE, adding refill_count to the selected inventory with saturation at 255; refill SHALL be ignored in other states.
REQ-030 SHALL accept both when refill_valid and bal_valid coincide in IDLE; SELECT SHALL then use the updated inventory.
REQ-031 SHALL on srst in any non-IDLE state go to IDLE next cycle with coin_req=0 and no done pulse; inventory already decremented SHALL be kept.
REQ-032 SHALL never underflow remaining or any inventory counter.

Reset
REQ-033 SHALL on hrst_n=0 immediately force state IDLE, all three inventories 0, remaining 0, and coin_req, coin_out, busy, done, short, jam and shortfall to 0.
REQ-034 SHALL leave srst with no effect on inventories or outputs while in IDLE.

Verification
REQ-035 SHALL cover exact payout: inventories Q=4 D=4 N=4, balance=65, ack 1 cycle after each req -> coins 11,11,10,01; done with short=0; inventories Q=2 D=3 N=3.
REQ-036 SHALL cover quarter shortage: Q=0 D=1 N=10, balance=30 -> coins 10,01,01,01,01; short=0; D=0 N=6.
REQ-037 SHALL cover odd cents: full inventory, balance=7 -> one nickel; done with short=1, shortfall=2.
REQ-038 SHALL cover jam: balance=25, Q=1, coin_ack held low -> done 256 cycles after coin_req rises; jam=1, shortfall=25, Q still 1.
REQ-039 SHALL cover abort: srst asserted during second ISSUE of a 65-cent payout -> IDLE next cycle; coin_req=0; no done pulse; Q decremented by 1 only.
REQ-040 SHALL cover refill saturation: Q=250 plus refill_type=11, refill_count=15 in IDLE -> quarter_cnt=255; the same refill during busy leaves the count unchanged.
